// File: rtl/spi16i_pkg.sv
// Shared definitions for the spi16i serial-in receive port: state encoding,
// word/counter widths and status register layout.
package spi16i_pkg;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

  localparam int ST_RDY     = 0;
  localparam int ST_OVR     = 1;
  localparam int ST_FERR    = 2;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_RX} state_t;

  function automatic logic [WORD_W-1:0] status_word(input logic r, input logic o,
                                                    input logic f,
                                                    input logic [CNT_W-1:0] c);
    logic [WORD_W-1:0] s;
    s = '0;
    s[ST_RDY]  = r;
    s[ST_OVR]  = o;
    s[ST_FERR] = f;
    s[ST_CNT_LSB +: CNT_W] = c;
    return s;
  endfunction
endpackage

// File: rtl/spi16i_sync_edge.sv
// N-stage synchronizer plus one extra register giving a single-cycle
// rising-edge pulse on the synchronized level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain <= {STAGES{RST_VAL}};
      q_d   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_d;
endmodule

// File: rtl/spi16i.sv
// SPI-style 16-bit serial receiver with a two-register parallel read port
// (data / status). Serial inputs are asynchronous and synchronized here.
module spi16i
  import spi16i_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iocs,
  input  logic              iord,
  input  logic              addr,
  output logic [WORD_W-1:0] dout,
  input  logic              sck,
  input  logic              sdi,
  input  logic              sync,
  output logic              rdy,
  output logic              err
);
  logic sck_s, sck_rise, sync_s, sync_rise, sdi_s;
  logic sck_level_unused;
  logic [SYNC_STAGES-1:0] sdi_chain;
  logic [SYNC_STAGES-1:0] warm;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d(sck), .q(sck_s), .rise(sck_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk(clk), .rst(rst), .d(sync), .q(sync_s), .rise(sync_rise)
  );
  assign sck_level_unused = sck_s;
  assign sdi_s = sdi_chain[SYNC_STAGES-1];

  state_t            state, state_n;
  logic [WORD_W-1:0] sreg, data;
  logic [CNT_W-1:0]  cnt, last_cnt;
  logic              ovr, ferr;
  logic              clr, shift, done, commit, ferr_ev;
  logic              data_rd, stat_rd;

  assign data_rd = iocs & iord & ~addr;
  assign stat_rd = iocs & iord & addr;

  // The sync synchronizer resets to idle-high, so WAIT only trusts sync_s once
  // the chain has been flushed with real pin samples after reset release.
  always_comb begin
    state_n = state;
    clr     = 1'b0;
    shift   = 1'b0;
    done    = 1'b0;
    commit  = 1'b0;
    ferr_ev = 1'b0;
    case (state)
      S_WAIT: if (warm[SYNC_STAGES-1] && sync_s) state_n = S_IDLE;
      // IDLE is only ever entered with sync_s high, so a low level is the fall.
      S_IDLE: if (!sync_s) begin
        state_n = S_RX;
        clr     = 1'b1;
      end
      S_RX: begin
        if (sync_rise) begin
          state_n = S_IDLE;
          done    = 1'b1;
          if (cnt == CNT_FULL) commit = 1'b1;
          else ferr_ev = 1'b1;
        end else if (sck_rise) begin
          shift = 1'b1;
        end
      end
      default: state_n = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_WAIT;
      sdi_chain <= '0;
      warm      <= '0;
      sreg      <= '0;
      data      <= '0;
      cnt       <= '0;
      last_cnt  <= '0;
      rdy       <= 1'b0;
      ovr       <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      state     <= state_n;
      sdi_chain <= {sdi_chain[SYNC_STAGES-2:0], sdi};
      warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
      if (clr) begin
        sreg <= '0;
        cnt  <= '0;
      end else if (shift) begin
        sreg <= {sreg[WORD_W-2:0], sdi_s};
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      end
      if (done)   last_cnt <= cnt;
      if (commit) data     <= sreg;
      // A commit beats a same-cycle data read; only an unread overwrite is an overrun.
      rdy <= commit | (rdy & ~data_rd);
      if (commit && rdy && !data_rd) ovr <= 1'b1;
      else if (stat_rd)              ovr <= 1'b0;
      if (ferr_ev)      ferr <= 1'b1;
      else if (stat_rd) ferr <= 1'b0;
    end
  end

  always_comb begin
    dout = '0;
    if (iocs && iord) dout = addr ? status_word(rdy, ovr, ferr, last_cnt) : data;
  end

  assign err = ovr | ferr;
endmodule

// File: tb/tb_spi16i.sv
// Randomized + directed bench for spi16i; a frame-level model predicts the
// register-visible state and is compared with the DUT every cycle.
module tb_spi16i;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst, iocs, iord, addr, sck, sdi, sync;
  logic [15:0] dout;
  logic        rdy, err;

  spi16i #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iord(iord), .addr(addr), .dout(dout),
    .sck(sck), .sdi(sdi), .sync(sync), .rdy(rdy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pending frame result: takes effect at the clk edge whose pre-edge cyc == ev_at
  int          ev_at = -1;
  int          ev_cnt;
  logic [15:0] ev_word;

  logic        m_rdy, m_ovr, m_ferr;
  logic [15:0] m_data;
  logic [4:0]  m_cnt;
  logic        drd, srd, com, fe;

  always @(posedge clk) begin
    drd = iocs & iord & ~addr;
    srd = iocs & iord & addr;
    if (!rst) begin
      m_rdy = 0; m_ovr = 0; m_ferr = 0; m_data = '0; m_cnt = '0;
    end else begin
      com = 0; fe = 0;
      if (cyc == ev_at) begin
        m_cnt = 5'(ev_cnt);
        if (ev_cnt == 16) com = 1; else fe = 1;
      end
      m_ovr  = (com && m_rdy && !drd) ? 1'b1 : (srd ? 1'b0 : m_ovr);
      m_ferr = fe ? 1'b1 : (srd ? 1'b0 : m_ferr);
      m_rdy  = com ? 1'b1 : (drd ? 1'b0 : m_rdy);
      if (com) m_data = ev_word;
    end
  end

  int          n_vec = 0, n_bad = 0;
  bit          chk_on = 0, lit_en = 0;
  logic [17:0] lit_exp;
  string       lit_name;
  logic [15:0] m_dout;

  always @(negedge clk) begin
    if (chk_on) begin
      m_dout = '0;
      if (iocs && iord)
        m_dout = addr ? {3'b0, m_cnt, 5'b0, m_ferr, m_ovr, m_rdy} : m_data;
      n_vec++;
      if ({err, rdy, dout} !== {m_ovr | m_ferr, m_rdy, m_dout}) begin
        n_bad++;
        $display("FAIL model cyc=%0d got err=%b rdy=%b dout=%h, want err=%b rdy=%b dout=%h",
                 cyc, err, rdy, dout, m_ovr | m_ferr, m_rdy, m_dout);
      end
      if (lit_en) begin
        n_vec++;
        if ({err, rdy, dout} !== lit_exp) begin
          n_bad++;
          $display("FAIL %s got err=%b rdy=%b dout=%h, want err=%b rdy=%b dout=%h",
                   lit_name, err, rdy, dout, lit_exp[17], lit_exp[16], lit_exp[15:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // MSB-first frame of nbits; bits above 15 are random filler. rst_at >= 0
  // pulses reset before that bit index and the frame then produces no result.
  task automatic send_frame(input logic [15:0] w, input int nbits, input int rst_at);
    int idx;
    logic b;
    sync = 0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin rst = 0; tick(3); rst = 1; end
      idx = nbits - 1 - i;
      if (idx < 16) b = w[idx]; else b = 1'($urandom_range(0, 1));
      sck = 0; sdi = b; tick(2);
      sck = 1; tick(2);
    end
    sck = 0;
    tick(2);
    if (rst_at < 0) begin
      ev_cnt  = (nbits > 17) ? 17 : nbits;
      ev_word = w;
      ev_at   = cyc + S;
    end
    sync = 1;
  endtask

  task automatic rd(input logic a, input bit lit, input logic [17:0] exp, input string nm);
    iocs = 1; iord = 1; addr = a;
    lit_en = lit; lit_exp = exp; lit_name = nm;
    tick(1);
    iocs = 0; iord = 0; addr = 0; lit_en = 0;
  endtask

  initial begin
    int nb, r;
    logic [15:0] w;
    rst = 0; iocs = 0; iord = 0; addr = 0; sck = 0; sdi = 0; sync = 1;
    tick(1);
    chk_on = 1;
    tick(3);
    rst = 1;
    tick(6);

    // 1: single word, read, then status
    send_frame(16'hA5C3, 16, -1); tick(6);
    rd(0, 1, {1'b0, 1'b1, 16'hA5C3}, "s1_data");
    rd(1, 1, {1'b0, 1'b0, 16'h1000}, "s1_status");

    // 2: overrun
    send_frame(16'h1234, 16, -1); tick(6);
    send_frame(16'hBEEF, 16, -1); tick(6);
    rd(1, 1, {1'b1, 1'b1, 16'h1003}, "s2_status");
    rd(0, 1, {1'b0, 1'b1, 16'hBEEF}, "s2_data");

    // 3: short frame, then count saturation on a long one
    send_frame(16'h0ABC, 12, -1); tick(6);
    rd(1, 1, {1'b1, 1'b0, 16'h0C04}, "s3_status1");
    rd(1, 1, {1'b0, 1'b0, 16'h0C00}, "s3_status2");
    send_frame(16'hFFFF, 20, -1); tick(6);
    rd(1, 1, {1'b1, 1'b0, 16'h1104}, "sat17_status");

    // 4: reset mid-frame, released while sync is low
    send_frame(16'h5A5A, 16, 7); tick(6);
    rd(1, 1, {1'b0, 1'b0, 16'h0000}, "s4_status");
    send_frame(16'h00FF, 16, -1); tick(6);
    rd(0, 1, {1'b0, 1'b1, 16'h00FF}, "s4_data");

    // 5: data read landing exactly on the next commit edge
    send_frame(16'h1111, 16, -1); tick(6);
    send_frame(16'h2222, 16, -1);
    while (cyc < ev_at) tick(1);
    rd(0, 1, {1'b0, 1'b1, 16'h1111}, "s5_commit_read");
    rd(1, 1, {1'b0, 1'b1, 16'h1001}, "s5_status");
    rd(0, 1, {1'b0, 1'b1, 16'h2222}, "s5_data");

    // 6: sck activity with sync high is ignored
    sync = 1;
    repeat (8) begin sck = 1; tick(2); sck = 0; tick(2); end
    rd(1, 1, {1'b0, 1'b0, 16'h1000}, "s6_status");
    send_frame(16'h8001, 16, -1); tick(6);
    rd(0, 1, {1'b0, 1'b1, 16'h8001}, "s6_data");

    // random frames and reads, model-checked every cycle
    for (int k = 0; k < 24; k++) begin
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
      w  = 16'($urandom);
      send_frame(w, nb, -1);
      tick(int'($urandom_range(4, 8)));
      r = int'($urandom_range(0, 3));
      if (r == 1 || r == 3) rd(1, 0, '0, "rand_status");
      if (r == 2 || r == 3) rd(0, 0, '0, "rand_data");
      tick(int'($urandom_range(1, 4)));
    end

    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
